lcd_status_writer: RTL and testbench

- Responder end of the LCDUpdate/LCDAck handshake driven by the reaction-timer FSM.
- Accepts a one-cycle update request and snapshots the status flags (Wait, Cheat, Slow) and the 10-bit reaction time.
- Formats a 16-character message and writes it to an HD44780-compatible character LCD over the 8-bit parallel bus.
- Holds LCDAck high while busy so the timer FSM will not start a new round mid-write.

---
 rtl/lcd_status_pkg.sv | 48 ++++
 rtl/lcd_bus_cycle.sv | 110 +++++++++++
 rtl/lcd_status_writer.sv | 169 ++++++++++++++++
 tb/tb_lcd_status_writer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_status_pkg.sv
// Shared constants, state encodings and helpers for the LCD status writer.
package lcd_status_pkg;

    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;

    // Character 0 sits in the top byte; the time template leaves blanks for the digit field.
    localparam logic [127:0] MSG_CHEAT = "CHEATER!        ";
    localparam logic [127:0] MSG_SLOW  = "TOO SLOW        ";
    localparam logic [127:0] MSG_WAIT  = "WAIT...         ";
    localparam logic [127:0] MSG_TIME  = "TIME      ms    ";

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_SNAP, S_CONV, S_CLEAR, S_WRITE, S_FINISH
    } state_t;

    typedef enum logic [2:0] {
        P_IDLE, P_SETUP, P_HIGH, P_WAIT, P_POLL_SETUP, P_POLL_HIGH
    } bus_phase_t;

    function automatic logic [7:0] msg_byte(input logic [127:0] msg, input logic [3:0] idx);
        logic [127:0] sh;
        sh = msg << {idx, 3'b000};
        return sh[127:120];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNCSET;
            2'd1:    return CMD_DISPON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

    // One double-dabble iteration: add 3 to every digit >= 5, then shift the next bit in.
    function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic bit_in);
        logic [15:0] adj;
        for (int i = 0; i < 4; i++) begin
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return {adj[14:0], bit_in};
    endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// Timed single-byte HD44780 write strobe; LCD_BUSYFLAG_EN replaces the fixed
// post-write wait with busy-flag polling when the caller requests it.
module lcd_bus_cycle
    import lcd_status_pkg::*;
#(
    parameter int SETUP_CYC      = 2,
    parameter int E_HIGH_CYC     = 4,
    parameter int CMD_WAIT_CYC   = 50,
    parameter int CLEAR_WAIT_CYC = 2000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       is_clear,
`ifdef LCD_BUSYFLAG_EN
    input  logic       poll,
    input  logic       db7,
`endif
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    bus_phase_t  phase;
    logic [15:0] cnt;
    logic        clear_wait;
`ifdef LCD_BUSYFLAG_EN
    logic        poll_l;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            phase      <= P_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            clear_wait <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_data   <= 8'h00;
`ifdef LCD_BUSYFLAG_EN
            poll_l     <= 1'b0;
`endif
        end else begin
            case (phase)
                P_IDLE: if (start) begin
                    lcd_rs     <= rs;
                    lcd_data   <= data;
                    clear_wait <= is_clear;
                    busy       <= 1'b1;
                    cnt        <= 16'(SETUP_CYC - 1);
                    phase      <= P_SETUP;
`ifdef LCD_BUSYFLAG_EN
                    poll_l     <= poll;
`endif
                end
                P_SETUP: if (cnt == '0) begin
                    lcd_e <= 1'b1;
                    cnt   <= 16'(E_HIGH_CYC - 1);
                    phase <= P_HIGH;
                end else cnt <= cnt - 16'd1;
                P_HIGH: if (cnt == '0) begin
                    lcd_e <= 1'b0;
`ifdef LCD_BUSYFLAG_EN
                    if (poll_l) begin
                        lcd_rs   <= 1'b0;
                        lcd_rw   <= 1'b1;
                        lcd_data <= 8'h00;
                        cnt      <= 16'(SETUP_CYC - 1);
                        phase    <= P_POLL_SETUP;
                    end else
`endif
                    begin
                        cnt   <= clear_wait ? 16'(CLEAR_WAIT_CYC - 1) : 16'(CMD_WAIT_CYC - 1);
                        phase <= P_WAIT;
                    end
                end else cnt <= cnt - 16'd1;
                P_WAIT: if (cnt == '0) begin
                    busy  <= 1'b0;
                    phase <= P_IDLE;
                end else cnt <= cnt - 16'd1;
`ifdef LCD_BUSYFLAG_EN
                P_POLL_SETUP: if (cnt == '0) begin
                    lcd_e <= 1'b1;
                    cnt   <= 16'(E_HIGH_CYC - 1);
                    phase <= P_POLL_HIGH;
                end else cnt <= cnt - 16'd1;
                // DB7 is sampled on the last E-high cycle; keep polling while the LCD reports busy.
                P_POLL_HIGH: if (cnt == '0) begin
                    lcd_e <= 1'b0;
                    if (!db7) begin
                        lcd_rw <= 1'b0;
                        busy   <= 1'b0;
                        phase  <= P_IDLE;
                    end else begin
                        cnt   <= 16'(SETUP_CYC - 1);
                        phase <= P_POLL_SETUP;
                    end
                end else cnt <= cnt - 16'd1;
`endif
                default: phase <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_status_writer.sv
// Snapshots the reaction-timer status on LCDUpdate and writes a 16-char line to an
// HD44780 LCD. Define LCD_BUSYFLAG_EN to poll the busy flag instead of fixed waits.
module lcd_status_writer
    import lcd_status_pkg::*;
#(
    parameter int INIT_WAIT_CYC  = 15000,
    parameter int SETUP_CYC      = 2,
    parameter int E_HIGH_CYC     = 4,
    parameter int CMD_WAIT_CYC   = 50,
    parameter int CLEAR_WAIT_CYC = 2000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       LCDUpdate,
    input  logic       Wait,
    input  logic       Cheat,
    input  logic       Slow,
    input  logic [9:0] ReactionTime,
`ifdef LCD_BUSYFLAG_EN
    input  logic       LCD_DB7_IN,
`endif
    output logic       LCDAck,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DATA
);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [3:0]  idx;
    logic [3:0]  conv_cnt;
    logic        issued;
    logic        pending;
    logic        bus_start;
    logic        bus_rs;
    logic        bus_clear;
    logic        bus_busy;
    logic [7:0]  bus_data;
    logic [7:0]  byte_sel;
    logic [7:0]  msg_char;
    logic        lat_wait;
    logic        lat_cheat;
    logic        lat_slow;
    logic [9:0]  bin;
    logic [15:0] bcd;
    logic        blank3;
    logic        blank2;
    logic        blank1;

    // Leading-zero blanking; the units digit is always shown.
    assign blank3 = (bcd[15:12] == 4'd0);
    assign blank2 = blank3 && (bcd[11:8] == 4'd0);
    assign blank1 = blank2 && (bcd[7:4] == 4'd0);

    always_comb begin
        msg_char = msg_byte(MSG_TIME, idx);
        if (lat_cheat)     msg_char = msg_byte(MSG_CHEAT, idx);
        else if (lat_slow) msg_char = msg_byte(MSG_SLOW, idx);
        else if (lat_wait) msg_char = msg_byte(MSG_WAIT, idx);
        else begin
            case (idx)
                4'd5:    msg_char = blank3 ? CHAR_SPACE : {4'h3, bcd[15:12]};
                4'd6:    msg_char = blank2 ? CHAR_SPACE : {4'h3, bcd[11:8]};
                4'd7:    msg_char = blank1 ? CHAR_SPACE : {4'h3, bcd[7:4]};
                4'd8:    msg_char = {4'h3, bcd[3:0]};
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_sel = CMD_CLEAR;
        if (state == S_INIT)       byte_sel = init_cmd(idx[1:0]);
        else if (state == S_WRITE) byte_sel = msg_char;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_PWRUP;
            wait_cnt  <= '0;
            idx       <= '0;
            issued    <= 1'b0;
            bus_start <= 1'b0;
            pending   <= 1'b0;
            LCDAck    <= 1'b1;
        end else begin
            bus_start <= 1'b0;
            case (state)
                S_PWRUP: if (wait_cnt == 16'(INIT_WAIT_CYC - 1)) begin
                    state <= S_INIT;
                    idx   <= '0;
                end else wait_cnt <= wait_cnt + 16'd1;
                S_IDLE: if (LCDUpdate || pending) begin
                    state  <= S_SNAP;
                    LCDAck <= 1'b1;
                end
                S_SNAP: begin
                    lat_wait  <= Wait;
                    lat_cheat <= Cheat;
                    lat_slow  <= Slow;
                    bin       <= ReactionTime;
                    bcd       <= '0;
                    conv_cnt  <= '0;
                    pending   <= 1'b0;
                    state     <= S_CONV;
                end
                S_CONV: begin
                    bcd      <= dabble_step(bcd, bin[9]);
                    bin      <= {bin[8:0], 1'b0};
                    conv_cnt <= conv_cnt + 4'd1;
                    if (conv_cnt == 4'd9) state <= S_CLEAR;
                end
                S_FINISH: begin
                    state  <= S_IDLE;
                    LCDAck <= 1'b0;
                end
                // S_INIT, S_CLEAR, S_WRITE: hand one byte to the bus engine, advance once it goes idle.
                default: begin
                    if (!issued) begin
                        bus_start <= 1'b1;
                        issued    <= 1'b1;
                        bus_rs    <= (state == S_WRITE);
                        bus_data  <= byte_sel;
                        bus_clear <= (state != S_WRITE) && (byte_sel == CMD_CLEAR);
                    end else if (!bus_start && !bus_busy) begin
                        issued <= 1'b0;
                        idx    <= idx + 4'd1;
                        if (state == S_INIT && idx == 4'd3) begin
                            state  <= S_IDLE;
                            LCDAck <= 1'b0;
                        end else if (state == S_CLEAR) begin
                            state <= S_WRITE;
                            idx   <= '0;
                        end else if (state == S_WRITE && idx == 4'd15) begin
                            state <= S_FINISH;
                        end
                    end
                end
            endcase
            // A request while busy is remembered; later ones collapse into it.
            if (LCDUpdate && LCDAck) pending <= 1'b1;
        end
    end

    lcd_bus_cycle #(
        .SETUP_CYC      (SETUP_CYC),
        .E_HIGH_CYC     (E_HIGH_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_bus (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (bus_start),
        .rs       (bus_rs),
        .data     (bus_data),
        .is_clear (bus_clear),
`ifdef LCD_BUSYFLAG_EN
        .poll     (state != S_INIT),
        .db7      (LCD_DB7_IN),
`endif
        .busy     (bus_busy),
        .lcd_rs   (LCD_RS),
        .lcd_rw   (LCD_RW),
        .lcd_e    (LCD_E),
        .lcd_data (LCD_DATA)
    );

endmodule

// File: tb/tb_lcd_status_writer.sv
// Scoreboard bench for lcd_status_writer: expected bus bytes are queued with each stimulus
// and checked, with strobe timing, by a monitor on every falling edge of LCD_E.
module tb_lcd_status_writer;

    localparam int INIT_W = 40;
    localparam int SETUP  = 2;
    localparam int EHIGH  = 4;
    localparam int CMDW   = 5;
    localparam int CLRW   = 20;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       LCDUpdate = 1'b0;
    logic       Wait = 1'b0;
    logic       Cheat = 1'b0;
    logic       Slow = 1'b0;
    logic [9:0] ReactionTime = '0;
    logic       LCDAck;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DATA;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];

    lcd_status_writer #(
        .INIT_WAIT_CYC  (INIT_W),
        .SETUP_CYC      (SETUP),
        .E_HIGH_CYC     (EHIGH),
        .CMD_WAIT_CYC   (CMDW),
        .CLEAR_WAIT_CYC (CLRW)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .LCDUpdate    (LCDUpdate),
        .Wait         (Wait),
        .Cheat        (Cheat),
        .Slow         (Slow),
        .ReactionTime (ReactionTime),
        .LCDAck       (LCDAck),
        .LCD_RS       (LCD_RS),
        .LCD_RW       (LCD_RW),
        .LCD_E        (LCD_E),
        .LCD_DATA     (LCD_DATA)
    );

    always #5 Clk = ~Clk;

    // Bus monitor: byte value at each E fall, E width, setup and post-write hold.
    logic       prev_e = 1'b0;
    logic       have_fall = 1'b0;
    logic       early_chg = 1'b0;
    logic [8:0] prev_bus = '0;
    int         hcnt = 0;
    int         stable = 0;
    int         gap = 0;
    int         need_w = 0;

    always @(negedge Clk) begin
        logic [8:0] cur;
        logic [8:0] want;
        cur = {LCD_RS, LCD_DATA};
        if (Rst) begin
            have_fall = 1'b0;
            early_chg = 1'b0;
            hcnt      = 0;
            stable    = 0;
            gap       = 0;
        end else if (LCD_E && !prev_e) begin
            n_checks++;
            if (stable >= SETUP && !early_chg && (!have_fall || gap >= need_w + SETUP - 1)) n_pass++;
            else $display("FAIL bus_timing: setup=%0d gap=%0d early_change=%0d, need setup>=%0d gap>=%0d",
                          stable, gap, early_chg, SETUP, need_w + SETUP - 1);
            hcnt      = 1;
            early_chg = 1'b0;
        end else if (LCD_E) begin
            hcnt++;
            if (cur != prev_bus) early_chg = 1'b1;
        end else if (prev_e) begin
            n_checks++;
            if (hcnt == EHIGH) n_pass++;
            else $display("FAIL e_width: got %0d cycles, want %0d", hcnt, EHIGH);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL byte_unexpected: got rw=%0b rs=%0b data=%02h, want no byte", LCD_RW, LCD_RS, LCD_DATA);
            end else begin
                want = exp_q.pop_front();
                if ({LCD_RW, cur} === {1'b0, want}) n_pass++;
                else $display("FAIL byte: got rw=%0b rs=%0b data=%02h, want rw=0 rs=%0b data=%02h",
                              LCD_RW, LCD_RS, LCD_DATA, want[8], want[7:0]);
            end
            if (cur != prev_bus) early_chg = 1'b1;
            have_fall = 1'b1;
            gap       = 0;
            need_w    = (cur == 9'h001) ? CLRW : CMDW;
        end else begin
            if (have_fall) gap++;
            if (cur != prev_bus) begin
                if (have_fall && gap < need_w) early_chg = 1'b1;
                stable = 1;
            end else stable++;
        end
        prev_e   = LCD_E;
        prev_bus = cur;
    end

    function automatic string model_msg(input logic w, input logic c, input logic s, input logic [9:0] rt);
        if (c) return "CHEATER!        ";
        if (s) return "TOO SLOW        ";
        if (w) return "WAIT...         ";
        return $sformatf("TIME %4d ms    ", int'(rt));
    endfunction

    task automatic expect_msg(input logic w, input logic c, input logic s, input logic [9:0] rt);
        string m;
        m = model_msg(w, c, s, rt);
        exp_q.push_back(9'h001);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, m[i]});
    endtask

    task automatic expect_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic pulse_update(input logic w, input logic c, input logic s, input logic [9:0] rt);
        expect_msg(w, c, s, rt);
        @(posedge Clk); #1;
        Wait = w; Cheat = c; Slow = s; ReactionTime = rt; LCDUpdate = 1'b1;
        @(posedge Clk); #1;
        LCDUpdate = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        for (int i = 0; i < budget && !(exp_q.size() == 0 && LCDAck === 1'b0); i++) @(negedge Clk);
    endtask

    task automatic test_reset();
        int   quiet;
        logic ack_ok;
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({LCDAck, LCD_E, LCD_RS, LCD_RW, LCD_DATA} === {4'b1000, 8'h00}) n_pass++;
        else $display("FAIL reset_outputs: got ack=%0b e=%0b rs=%0b rw=%0b data=%02h, want 1 0 0 0 00",
                      LCDAck, LCD_E, LCD_RS, LCD_RW, LCD_DATA);
        expect_init();
        @(posedge Clk); #1;
        Rst = 1'b0;
        quiet  = 0;
        ack_ok = 1'b1;
        for (int i = 0; i < INIT_W + 20 && !LCD_E; i++) begin
            @(negedge Clk);
            if (!LCD_E) quiet++;
            if (LCDAck !== 1'b1) ack_ok = 1'b0;
        end
        n_checks++;
        if (LCD_E === 1'b1 && ack_ok && quiet >= INIT_W && quiet <= INIT_W + SETUP + 6) n_pass++;
        else $display("FAIL powerup_wait: got quiet=%0d e=%0b ack_high=%0b, want quiet %0d..%0d then E",
                      quiet, LCD_E, ack_ok, INIT_W, INIT_W + SETUP + 6);
        wait_quiet(2000);
        n_checks++;
        if (exp_q.size() == 0 && LCDAck === 1'b0) n_pass++;
        else $display("FAIL init_done: got pending_bytes=%0d ack=%0b, want 0 0", exp_q.size(), LCDAck);
    endtask

    task automatic test_wait_msg();
        logic held;
        n_checks++;
        if (LCDAck === 1'b0) n_pass++;
        else $display("FAIL idle_ack: got %0b, want 0", LCDAck);
        pulse_update(1'b1, 1'b0, 1'b0, 10'd300);
        held = 1'b1;
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) begin
            @(negedge Clk);
            if (LCDAck !== 1'b1) held = 1'b0;
        end
        n_checks++;
        if (held && exp_q.size() == 0) n_pass++;
        else $display("FAIL ack_held: got held=%0b left=%0d, want 1 0", held, exp_q.size());
        wait_quiet(1000);
        n_checks++;
        if (exp_q.size() == 0 && LCDAck === 1'b0) n_pass++;
        else $display("FAIL wait_msg_done: got left=%0d ack=%0b, want 0 0", exp_q.size(), LCDAck);
    endtask

    task automatic test_time_msgs();
        logic [9:0] times[5] = '{10'd237, 10'd0, 10'd1023, 10'd100, 10'd10};
        foreach (times[k]) begin
            pulse_update(1'b0, 1'b0, 1'b0, times[k]);
            wait_quiet(4000);
            n_checks++;
            if (exp_q.size() == 0 && LCDAck === 1'b0) n_pass++;
            else $display("FAIL time_msg_%0d: got left=%0d ack=%0b, want 0 0", times[k], exp_q.size(), LCDAck);
        end
    endtask

    task automatic test_priority();
        logic [3:0] combos[3] = '{4'b0110, 4'b0010, 4'b1010};
        foreach (combos[k]) begin
            pulse_update(combos[k][3], combos[k][2], combos[k][1], 10'd5);
            wait_quiet(4000);
            n_checks++;
            if (exp_q.size() == 0 && LCDAck === 1'b0) n_pass++;
            else $display("FAIL priority_%0d: got left=%0d ack=%0b, want 0 0", k, exp_q.size(), LCDAck);
        end
    endtask

    task automatic test_back_to_back();
        logic saw_e;
        pulse_update(1'b0, 1'b0, 1'b0, 10'd42);
        for (int i = 0; i < 4000 && exp_q.size() > 10; i++) @(negedge Clk);
        @(posedge Clk); #1 LCDUpdate = 1'b1;
        @(posedge Clk); #1 LCDUpdate = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Slow = 1'b1;
        @(posedge Clk); #1 LCDUpdate = 1'b1;
        @(posedge Clk); #1 LCDUpdate = 1'b0;
        expect_msg(1'b0, 1'b0, 1'b1, 10'd42);
        wait_quiet(8000);
        n_checks++;
        if (exp_q.size() == 0 && LCDAck === 1'b0) n_pass++;
        else $display("FAIL collapse_done: got left=%0d ack=%0b, want 0 0", exp_q.size(), LCDAck);
        saw_e = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge Clk);
            if (LCD_E || LCDAck) saw_e = 1'b1;
        end
        n_checks++;
        if (!saw_e) n_pass++;
        else $display("FAIL collapse_extra: got extra activity=1, want 0");
    endtask

    task automatic test_reset_mid();
        int   n;
        int   quiet;
        logic pe;
        logic saw_e;
        pulse_update(1'b0, 1'b0, 1'b0, 10'd512);
        n  = 0;
        pe = LCD_E;
        for (int i = 0; i < 4000 && n < 8; i++) begin
            @(negedge Clk);
            if (LCD_E && !pe && LCD_RS) n++;
            pe = LCD_E;
        end
        n_checks++;
        if (n == 8 && LCD_E === 1'b1) n_pass++;
        else $display("FAIL reach_byte8: got rises=%0d e=%0b, want 8 1", n, LCD_E);
        Rst = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (LCD_E === 1'b0 && LCDAck === 1'b1) n_pass++;
        else $display("FAIL mid_reset: got e=%0b ack=%0b, want 0 1", LCD_E, LCDAck);
        exp_q.delete();
        expect_init();
        @(posedge Clk); #1;
        Rst   = 1'b0;
        quiet = 0;
        for (int i = 0; i < INIT_W + 20 && !LCD_E; i++) begin
            @(negedge Clk);
            if (!LCD_E) quiet++;
        end
        n_checks++;
        if (LCD_E === 1'b1 && quiet >= INIT_W && quiet <= INIT_W + SETUP + 6) n_pass++;
        else $display("FAIL repowerup_wait: got quiet=%0d e=%0b, want %0d..%0d then E",
                      quiet, LCD_E, INIT_W, INIT_W + SETUP + 6);
        wait_quiet(2000);
        saw_e = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (LCD_E || LCDAck) saw_e = 1'b1;
        end
        n_checks++;
        if (exp_q.size() == 0 && !saw_e) n_pass++;
        else $display("FAIL reinit_done: got left=%0d activity=%0b, want 0 0", exp_q.size(), saw_e);
    endtask

    initial begin
        test_reset();
        test_wait_msg();
        test_time_msgs();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
